// File: rtl/rr_stream_mux_if.sv
// Purpose : bundles the N-channel input streams and the single output stream of rr_stream_mux.
// Latency : n/a (wires only).
// Backpressure: in_ready driven by the mux, out_ready driven by the downstream consumer.
// Ports   : mode/sel configuration, in_data/in_valid/in_last/in_ready per channel,
//           out_data/out_valid/out_last/out_ch/out_ready on the merged stream.
interface rr_stream_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [N_CH*WIDTH-1:0]   in_data;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH-1:0]         in_last;
    logic [N_CH-1:0]         in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_last;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_ready;

    // Sources and downstream consumer side.
    modport master (
        output mode, sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch
    );

    // Multiplexer side.
    modport slave (
        input  mode, sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch
    );
endinterface

// File: rtl/rr_stream_mux.sv
// Purpose : N-channel packet stream mux, fixed-select or round-robin, grant held for a whole packet.
// Latency : one cycle from input handshake to registered out_*.
// Backpressure: single-entry output register; in_ready only when out_ready or output empty.
// Ports   : clk, rst (sync, active-high); bus = rr_stream_mux_if.slave carrying
//           mode/sel, per-channel in_* streams and the registered out_* stream.
module rr_stream_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2   // must be clog2(N_CH), at least 1
) (
    input  logic                clk,
    input  logic                rst,
    rr_stream_mux_if.slave      bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SEL_W:0]   LP_N_CH = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(N_CH - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [SEL_W-1:0]   r_lock_ch;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic [SEL_W-1:0]   r_out_ch;

    logic               w_accept;
    logic               w_grant_vld;
    logic [SEL_W-1:0]   w_grant;
    logic [N_CH-1:0]    w_in_ready;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_dat;
    logic               w_last;
    logic [SEL_W-1:0]   w_rr_next;

    // Output register is a single entry: it can take a beat if empty or draining this cycle.
    assign w_accept = bus.out_ready | ~r_out_valid;

    // Grant selection. In round-robin the loop runs from the farthest offset down to
    // offset 0 so the valid channel closest to rr_ptr is the last one written and wins.
    always_comb begin
        logic [SEL_W-1:0] v_idx;
        v_idx       = '0;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        if (r_state == LOCKED) begin
            w_grant_vld = 1'b1;
            w_grant     = r_lock_ch;
        end else if (!bus.mode) begin
            if ({1'b0, bus.sel} < LP_N_CH) begin
                w_grant_vld = 1'b1;
                w_grant     = bus.sel;
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                v_idx = SEL_W'((int'(r_rr_ptr) + i) % N_CH);
                if (bus.in_valid[v_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = v_idx;
                end
            end
        end
    end

    // One-hot ready plus a one-hot data/last mux keyed on the grant.
    always_comb begin
        w_in_ready = '0;
        w_dat      = '0;
        w_last     = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_in_ready[k] = ~rst & w_accept & w_grant_vld;
                w_dat         = bus.in_data[k*WIDTH +: WIDTH];
                w_last        = bus.in_last[k];
            end
        end
    end

    assign w_xfer    = |(w_in_ready & bus.in_valid);
    assign w_rr_next = (w_grant == LP_LAST) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_lock_ch   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_dat;
            r_out_last  <= w_last;
            r_out_ch    <= w_grant;
            r_out_valid <= 1'b1;
            if (w_last) begin
                // Single-beat packets go straight back to IDLE; the pointer only moves at packet end.
                r_state <= IDLE;
                if (bus.mode) begin
                    r_rr_ptr <= w_rr_next;
                end
            end else begin
                r_state   <= LOCKED;
                r_lock_ch <= w_grant;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    rr_stream_mux_if #(.N_CH(4), .WIDTH(8), .SEL_W(2)) bus ();

    rr_stream_mux #(.N_CH(4), .WIDTH(8), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_ch(input int k, input logic v, input logic [7:0] d, input logic l);
        bus.in_valid[k]      = v;
        bus.in_data[k*8 +: 8] = d;
        bus.in_last[k]       = l;
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] ch, input logic l);
        chk({tag, "_vld"}, bus.out_valid, 1'b1);
        chk({tag, "_dat"}, bus.out_data, d);
        chk({tag, "_ch"}, bus.out_ch, ch);
        chk({tag, "_last"}, bus.out_last, l);
    endtask

    initial begin
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'hF;
        bus.in_last   = 4'hF;
        bus.in_data   = 32'h13121110;

        // Reset held two cycles with every channel valid.
        tick();
        chk("rst1_rdy", bus.in_ready, 4'b0000);
        tick();
        chk("rst2_rdy", bus.in_ready, 4'b0000);
        chk("rst_vld", bus.out_valid, 1'b0);
        chk("rst_dat", bus.out_data, 8'h00);
        chk("rst_ch", bus.out_ch, 2'd0);
        chk("rst_last", bus.out_last, 1'b0);

        // Round-robin fairness with single-beat packets, first grant is ch0.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr%0d_rdy", i), bus.in_ready, 4'b0001 << (i % 4));
            tick();
            chk_out($sformatf("rr%0d", i), 8'h10 + 8'(i % 4), 2'(i % 4), 1'b1);
        end
        bus.in_valid = 4'h0;
        tick();
        chk("rr_drain_vld", bus.out_valid, 1'b0);

        // Fixed select: ch2 three-beat packet, other channels valid but blocked. rr_ptr is 2.
        bus.mode = 1'b0;
        bus.sel  = 2'd2;
        set_ch(0, 1'b1, 8'hE0, 1'b1);
        set_ch(1, 1'b1, 8'hE1, 1'b1);
        set_ch(3, 1'b1, 8'hE3, 1'b1);
        set_ch(2, 1'b1, 8'hA1, 1'b0);
        #1 chk("fix_a1_rdy", bus.in_ready, 4'b0100);
        tick();
        chk_out("fix_a1", 8'hA1, 2'd2, 1'b0);
        set_ch(2, 1'b1, 8'hA2, 1'b0);
        #1 chk("fix_a2_rdy", bus.in_ready, 4'b0100);
        tick();
        chk_out("fix_a2", 8'hA2, 2'd2, 1'b0);
        set_ch(2, 1'b1, 8'hA3, 1'b1);
        #1 chk("fix_a3_rdy", bus.in_ready, 4'b0100);
        tick();
        chk_out("fix_a3", 8'hA3, 2'd2, 1'b1);
        bus.in_valid = 4'h0;
        tick();
        chk("fix_drain_vld", bus.out_valid, 1'b0);

        // Round-robin: one ch0 beat moves rr_ptr from 2 to 1.
        bus.mode = 1'b1;
        set_ch(0, 1'b1, 8'h20, 1'b1);
        #1 chk("pre_rdy", bus.in_ready, 4'b0001);
        tick();
        chk_out("pre", 8'h20, 2'd0, 1'b1);

        // Packet lock: ch1 four beats with a two-cycle bubble, ch0/ch3 valid throughout.
        set_ch(0, 1'b1, 8'h30, 1'b1);
        set_ch(3, 1'b1, 8'h5A, 1'b1);
        set_ch(1, 1'b1, 8'hB1, 1'b0);
        #1 chk("lk_b1_rdy", bus.in_ready, 4'b0010);
        tick();
        chk_out("lk_b1", 8'hB1, 2'd1, 1'b0);
        set_ch(1, 1'b1, 8'hB2, 1'b0);
        tick();
        chk_out("lk_b2", 8'hB2, 2'd1, 1'b0);
        set_ch(1, 1'b0, 8'hXX, 1'b0);
        #1 chk("lk_bub1_rdy", bus.in_ready, 4'b0010);
        tick();
        chk("lk_bub1_vld", bus.out_valid, 1'b0);
        #1 chk("lk_bub2_rdy", bus.in_ready, 4'b0010);
        tick();
        chk("lk_bub2_vld", bus.out_valid, 1'b0);
        set_ch(1, 1'b1, 8'hB3, 1'b0);
        tick();
        chk_out("lk_b3", 8'hB3, 2'd1, 1'b0);
        set_ch(1, 1'b1, 8'hB4, 1'b1);
        tick();
        chk_out("lk_b4", 8'hB4, 2'd1, 1'b1);
        set_ch(1, 1'b0, 8'h00, 1'b0);
        // rr_ptr is now 2, ch2 idle, so ch3 wins over ch0.
        #1 chk("lk_next_rdy", bus.in_ready, 4'b1000);
        tick();
        chk_out("lk_next", 8'h5A, 2'd3, 1'b1);

        // Backpressure: output holds and nothing is accepted.
        bus.out_ready = 1'b0;
        set_ch(3, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("bp%0d_rdy", i), bus.in_ready, 4'b0000);
            tick();
            chk_out($sformatf("bp%0d", i), 8'h5A, 2'd3, 1'b1);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_rel_rdy", bus.in_ready, 4'b0001);
        tick();
        chk_out("bp_next", 8'h30, 2'd0, 1'b1);
        bus.in_valid = 4'h0;
        tick();
        chk("bp_drain_vld", bus.out_valid, 1'b0);

        // Deferred select change: sel 2->0 mid-packet on ch2.
        bus.mode = 1'b0;
        bus.sel  = 2'd2;
        set_ch(0, 1'b1, 8'hD0, 1'b1);
        set_ch(2, 1'b1, 8'hC1, 1'b0);
        #1 chk("ds_c1_rdy", bus.in_ready, 4'b0100);
        tick();
        chk_out("ds_c1", 8'hC1, 2'd2, 1'b0);
        bus.sel = 2'd0;
        set_ch(2, 1'b1, 8'hC2, 1'b0);
        #1 chk("ds_c2_rdy", bus.in_ready, 4'b0100);
        tick();
        chk_out("ds_c2", 8'hC2, 2'd2, 1'b0);
        set_ch(2, 1'b1, 8'hC3, 1'b1);
        #1 chk("ds_c3_rdy", bus.in_ready, 4'b0100);
        tick();
        chk_out("ds_c3", 8'hC3, 2'd2, 1'b1);
        set_ch(2, 1'b0, 8'h00, 1'b0);
        #1 chk("ds_d0_rdy", bus.in_ready, 4'b0001);
        tick();
        chk_out("ds_d0", 8'hD0, 2'd0, 1'b1);

        // Reset during beat 2 of a ch2 packet aborts it.
        bus.sel = 2'd2;
        set_ch(0, 1'b0, 8'h00, 1'b0);
        set_ch(2, 1'b1, 8'hE1, 1'b0);
        tick();
        chk_out("mr_e1", 8'hE1, 2'd2, 1'b0);
        set_ch(2, 1'b1, 8'hE2, 1'b0);
        rst = 1'b1;
        #1 chk("mr_rst_rdy", bus.in_ready, 4'b0000);
        tick();
        chk("mr_rst_vld", bus.out_valid, 1'b0);
        chk("mr_rst_dat", bus.out_data, 8'h00);
        rst     = 1'b0;
        bus.sel = 2'd0;
        set_ch(0, 1'b1, 8'hF1, 1'b1);
        #1 chk("mr_f1_rdy", bus.in_ready, 4'b0001);
        tick();
        chk_out("mr_f1", 8'hF1, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Parametrised N-channel streaming multiplexer that generalises the 2:1 select mux. Each input is a valid/ready stream with packet framing (last). The block grants one channel at a time, by either fixed select or round-robin arbitration, and holds the grant for a whole packet. Output is registered with a valid/ready handshake. It sits between multiple packet sources and a single downstream consumer.

Parameters:
N_CH, 4, number of input channels (2..16)
WIDTH, 8, data width per channel
SEL_W, 2, width of sel/out_ch; must equal clog2(N_CH), minimum 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select via sel; 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  N_CH  per-channel valid
in_last  input  N_CH  per-channel end-of-packet flag
in_ready  output  N_CH  per-channel ready (combinational)
out_data  output  WIDTH  registered data
out_valid  output  1  registered valid
out_last  output  1  registered end-of-packet
out_ch  output  SEL_W  source channel of the current out_data
out_ready  input  1  downstream ready

Behaviour:
- One clock; reset is synchronous and active-high. On a clk edge with rst=1: out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, rr_ptr=0, lock_ch=0. While rst=1, in_ready is all 0.
- States: IDLE (no packet in progress) and LOCKED (mid-packet on lock_ch).
- accept = out_ready | ~out_valid. The output register has a single entry with full throughput, so back-to-back beats are allowed when out_ready=1.
- Grant g:
  - LOCKED: g = lock_ch. mode and sel are ignored.
  - IDLE, mode=0: g = sel. If sel >= N_CH, there is no grant and in_ready is all 0.
  - IDLE, mode=1: g = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... with wrap mod N_CH. If no channel is valid, there is no grant.
- in_ready[k] = ~rst & accept & grant_exists & (k==g). All other bits are 0.
- xfer = in_valid[g] & in_ready[g]. On xfer the next edge does the following:
  - out_data <= in_data[g]; out_last <= in_last[g]; out_ch <= g; out_valid <= 1.
  - If in_last[g]=1: state <= IDLE. In mode=1, rr_ptr <= (g+1) mod N_CH. A single-beat packet never enters LOCKED.
  - Else: state <= LOCKED; lock_ch <= g.
- No xfer and out_ready=1: out_valid <= 0. No xfer and out_ready=0: all output registers hold.
- Latency: an input beat appears on out_* one cycle after its handshake.
- rr_ptr advances only at packet end in mode=1. It is unchanged in mode=0.
- mode/sel changes take effect only in IDLE. A change mid-packet is deferred until the last beat is accepted.
- An in_valid drop mid-packet (bubble) keeps LOCKED. Other channels stay blocked.
- Downstream backpressure: out_* must stay stable while out_valid=1 and out_ready=0.
- Reset mid-packet aborts the packet: state=IDLE, out_valid=0 on the next edge, with no partial flush.
- in_data/in_last of channels that are not granted are don't-care.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_ch=0. The first grant after release in mode=1 is ch0.
- Fixed mode: mode=0, sel=2, ch2 sends 3 beats A1,A2,A3 (last on A3) with out_ready=1 -> out_data A1,A2,A3 on consecutive cycles, each 1 cycle after its handshake; out_ch=2; out_last=1 only with A3; in_ready[0,1,3]=0 throughout.
- Round-robin fairness: mode=1, all 4 channels continuously valid with single-beat packets (data = 0x10+k) -> out_ch sequence 0,1,2,3,0,1; out_data 0x10,0x11,0x12,0x13,...
- Packet lock: mode=1, ch1 sends a 4-beat packet with a 2-cycle in_valid bubble after beat 2 while ch0 and ch3 are valid -> all 4 beats are output with out_ch=1 and no interleaving; the next grant goes to ch3 (rr_ptr=2, ch2 idle).
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 with out_data=0x5A -> out_data/out_last/out_ch stay stable and in_ready is all 0. Raising out_ready drains 0x5A, and the next beat is accepted in the same cycle.
- Mid-packet reset and deferred select: change sel 2->0 mid-packet -> ch2 completes, then ch0 is granted. Separately, assert rst during beat 2 of a packet -> out_valid=0 next cycle, state IDLE, and a fresh packet from ch0 is granted after release.
